// File: rtl/vx_aging_priority_arbiter_pkg.sv
// Shared types for the aging priority arbiter: lock-state encoding, default age type
// and the index-width helper.
package vx_arb_pkg;

  localparam int ARB_AGE_WIDTH_DEF = 4;

  // Default-width age counter; the arbiter declares its own width-matched copy.
  typedef logic [ARB_AGE_WIDTH_DEF-1:0] arb_age_t;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_lock_state_e;

  // Index width that stays at least one bit wide for a single requester.
  function automatic int log2up(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_aging_priority_arbiter_penc.sv
// Lowest-index-wins priority encoder producing index, one-hot and valid.
module VX_priority_encoder #(
  parameter int N    = 4,
  parameter int LOGN = 2
) (
  input  logic [N-1:0]    data_i,
  output logic [LOGN-1:0] index_o,
  output logic [N-1:0]    onehot_o,
  output logic            valid_o
);

  // Isolate the lowest set bit, then fold the one-hot back into a binary index.
  always_comb begin
    onehot_o = data_i & (~data_i + N'(1));
    index_o  = '0;
    for (int i = 0; i < N; i++) begin
      index_o = index_o | (LOGN'(i) & {LOGN{onehot_o[i]}});
    end
    valid_o = |data_i;
  end

endmodule

// File: rtl/vx_aging_priority_arbiter.sv
// Fixed-priority arbiter with per-requester starvation aging and optional grant lock.
// Optional perf counter of promoted grants is enabled with VX_AGING_ARB_PERF_EN.
module vx_aging_priority_arbiter
  import vx_arb_pkg::*;
#(
  parameter int NUM_REQS     = 4,
  parameter int LOCK_ENABLE  = 0,
  parameter int AGE_WIDTH    = 4,
  parameter int MAX_AGE      = 15,
  parameter int LOG_NUM_REQS = log2up(NUM_REQS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQS-1:0]     requests,
  input  logic                    unlock,
  output logic [LOG_NUM_REQS-1:0] grant_index,
  output logic [NUM_REQS-1:0]     grant_onehot,
  output logic                    grant_valid,
  output logic [NUM_REQS-1:0]     starved
`ifdef VX_AGING_ARB_PERF_EN
  ,
  output logic [31:0]             perf_promoted_grants
`endif
);

  typedef logic [AGE_WIDTH-1:0] age_t;
  localparam age_t MAX_AGE_C = age_t'(MAX_AGE);

  if (NUM_REQS < 1) begin : g_bad_num_reqs
    $error("vx_aging_priority_arbiter: NUM_REQS must be at least 1");
  end
  if ((MAX_AGE < 1) || (MAX_AGE > ((2 ** AGE_WIDTH) - 1))) begin : g_bad_max_age
    $error("vx_aging_priority_arbiter: MAX_AGE must lie in 1 .. 2**AGE_WIDTH-1");
  end

  logic [NUM_REQS-1:0]     starved_s;
  logic [NUM_REQS-1:0]     starved_req_s;
  logic [LOG_NUM_REQS-1:0] st_idx_s;
  logic [NUM_REQS-1:0]     st_oh_s;
  logic                    st_vld_s;
  logic [LOG_NUM_REQS-1:0] pl_idx_s;
  logic [NUM_REQS-1:0]     pl_oh_s;
  logic                    pl_vld_s;

  arb_lock_state_e         lock_state_q;
  logic [LOG_NUM_REQS-1:0] lock_idx_q;
  logic                    lock_hold_s;

  logic [LOG_NUM_REQS-1:0] grant_index_s;
  logic [NUM_REQS-1:0]     grant_onehot_s;
  logic                    grant_valid_s;
  logic                    promoted_s;
  logic                    accept_s;

  assign starved_req_s = starved_s & requests;

  VX_priority_encoder #(
    .N    (NUM_REQS),
    .LOGN (LOG_NUM_REQS)
  ) u_starved_enc (
    .data_i   (starved_req_s),
    .index_o  (st_idx_s),
    .onehot_o (st_oh_s),
    .valid_o  (st_vld_s)
  );

  VX_priority_encoder #(
    .N    (NUM_REQS),
    .LOGN (LOG_NUM_REQS)
  ) u_plain_enc (
    .data_i   (requests),
    .index_o  (pl_idx_s),
    .onehot_o (pl_oh_s),
    .valid_o  (pl_vld_s)
  );

  // A held lock only counts while its owner keeps requesting; a withdrawn owner
  // releases the grant in the same cycle.
  assign lock_hold_s = (lock_state_q == ARB_LOCKED) && requests[lock_idx_q];

  // Grant selection: lock, then starved requesters, then plain priority.
  always_comb begin
    grant_index_s  = pl_idx_s;
    grant_onehot_s = pl_oh_s;
    grant_valid_s  = pl_vld_s;
    promoted_s     = 1'b0;
    if (lock_hold_s) begin
      grant_index_s  = lock_idx_q;
      grant_onehot_s = NUM_REQS'(1) << lock_idx_q;
      grant_valid_s  = 1'b1;
    end else if (st_vld_s) begin
      grant_index_s  = st_idx_s;
      grant_onehot_s = st_oh_s;
      grant_valid_s  = 1'b1;
      promoted_s     = 1'b1;
    end else begin
      grant_index_s  = pl_idx_s;
      grant_onehot_s = pl_oh_s;
      grant_valid_s  = pl_vld_s;
    end
  end

  assign accept_s = grant_valid_s && unlock;

  if (LOCK_ENABLE != 0) begin : g_lock
    arb_lock_state_e         lock_state_d;
    logic [LOG_NUM_REQS-1:0] lock_idx_d;

    // Lock state register.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        lock_state_q <= ARB_IDLE;
        lock_idx_q   <= '0;
      end else begin
        lock_state_q <= lock_state_d;
        lock_idx_q   <= lock_idx_d;
      end
    end

    // Lock next state: capture an unaccepted grant, release on accept or withdrawal.
    always_comb begin
      lock_state_d = lock_state_q;
      lock_idx_d   = lock_idx_q;
      case (lock_state_q)
        ARB_IDLE: begin
          if (grant_valid_s && !unlock) begin
            lock_state_d = ARB_LOCKED;
            lock_idx_d   = grant_index_s;
          end else begin
            lock_state_d = ARB_IDLE;
          end
        end
        ARB_LOCKED: begin
          if (accept_s || !requests[lock_idx_q]) begin
            lock_state_d = ARB_IDLE;
          end else begin
            lock_state_d = ARB_LOCKED;
          end
        end
        default: begin
          lock_state_d = ARB_IDLE;
          lock_idx_d   = '0;
        end
      endcase
    end
  end else begin : g_nolock
    assign lock_state_q = ARB_IDLE;
    assign lock_idx_q   = '0;
  end

  for (genvar i = 0; i < NUM_REQS; i++) begin : g_age
    age_t age_q;
    age_t age_d;

    // Age next state: clear when idle or served, otherwise count up and saturate.
    always_comb begin
      if (!requests[i] || (accept_s && grant_onehot_s[i])) begin
        age_d = '0;
      end else if (age_q == MAX_AGE_C) begin
        age_d = age_q;
      end else begin
        age_d = age_q + age_t'(1);
      end
    end

    // Age register.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        age_q <= '0;
      end else begin
        age_q <= age_d;
      end
    end

    assign starved_s[i] = (age_q == MAX_AGE_C);
  end

`ifdef VX_AGING_ARB_PERF_EN
  logic [31:0] perf_q;

  // Count accepted grants won through the starvation path; wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_q <= 32'd0;
    end else if (accept_s && promoted_s) begin
      perf_q <= perf_q + 32'd1;
    end else begin
      perf_q <= perf_q;
    end
  end

  assign perf_promoted_grants = perf_q;
`endif

  assign grant_index  = grant_index_s;
  assign grant_onehot = grant_onehot_s;
  assign grant_valid  = grant_valid_s;
  assign starved      = starved_s;

endmodule

// File: tb/tb_vx_aging_priority_arbiter.sv
// Randomized and directed checks of the aging arbiter (lock off and lock on)
// against a behavioural reference model.
module tb_vx_aging_priority_arbiter;

  localparam int N  = 4;
  localparam int MA = 3;
  localparam int LW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req;
  logic          unl;

  logic [LW-1:0] gidx0, gidx1;
  logic [N-1:0]  goh0, goh1, st0, st1;
  logic          gv0, gv1;
`ifdef VX_AGING_ARB_PERF_EN
  logic [31:0]   perf0, perf1;
`endif

  always #5 clk = ~clk;

  vx_aging_priority_arbiter #(.NUM_REQS(N), .LOCK_ENABLE(0), .AGE_WIDTH(4), .MAX_AGE(MA)) d0 (
    .clk(clk), .reset(reset), .requests(req), .unlock(unl),
    .grant_index(gidx0), .grant_onehot(goh0), .grant_valid(gv0), .starved(st0)
`ifdef VX_AGING_ARB_PERF_EN
    , .perf_promoted_grants(perf0)
`endif
  );

  vx_aging_priority_arbiter #(.NUM_REQS(N), .LOCK_ENABLE(1), .AGE_WIDTH(4), .MAX_AGE(MA)) d1 (
    .clk(clk), .reset(reset), .requests(req), .unlock(unl),
    .grant_index(gidx1), .grant_onehot(goh1), .grant_valid(gv1), .starved(st1)
`ifdef VX_AGING_ARB_PERF_EN
    , .perf_promoted_grants(perf1)
`endif
  );

  // Reference state: waiting time per requester, lock owner (-1 = none), promoted count.
  int age [2][N];
  int lk  [2];
  int perf[2];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < N; i++) age[d][i] = 0;
      lk[d]   = -1;
      perf[d] = 0;
    end
  endfunction

  // Which requester should win right now, and whether it won by starvation.
  function automatic void model_sel(input int d, output int idx, output int vld, output int prom);
    idx = 0; vld = 0; prom = 0;
    if (lk[d] >= 0 && req[lk[d]]) begin
      idx = lk[d]; vld = 1;
      return;
    end
    for (int i = 0; i < N; i++) begin
      if (req[i] && age[d][i] == MA && prom == 0) begin
        idx = i; vld = 1; prom = 1;
      end
    end
    if (prom == 0) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (req[i]) begin idx = i; vld = 1; end
      end
    end
  endfunction

  function automatic void model_clock();
    int idx, vld, prom, acc;
    for (int d = 0; d < 2; d++) begin
      model_sel(d, idx, vld, prom);
      acc = vld & int'(unl);
      for (int i = 0; i < N; i++) begin
        if (!req[i] || (acc != 0 && idx == i)) age[d][i] = 0;
        else if (age[d][i] < MA) age[d][i] = age[d][i] + 1;
      end
      if (acc != 0 && prom != 0) perf[d] = perf[d] + 1;
      if (d == 1) begin
        if (lk[d] >= 0) begin
          if (acc != 0 || !req[lk[d]]) lk[d] = -1;
        end else if (vld != 0 && !unl) begin
          lk[d] = idx;
        end
      end
    end
  endfunction

  task automatic check_all();
    int idx, vld, prom;
    logic [N-1:0] st_exp;
    for (int d = 0; d < 2; d++) begin
      model_sel(d, idx, vld, prom);
      st_exp = '0;
      for (int i = 0; i < N; i++) st_exp[i] = (age[d][i] == MA);
      chk($sformatf("d%0d_idx", d), (d == 0) ? gidx0 : gidx1, idx);
      chk($sformatf("d%0d_vld", d), (d == 0) ? gv0 : gv1, vld);
      chk($sformatf("d%0d_oh", d), (d == 0) ? goh0 : goh1, (vld != 0) ? (32'd1 << idx) : 32'd0);
      chk($sformatf("d%0d_starved", d), (d == 0) ? st0 : st1, st_exp);
`ifdef VX_AGING_ARB_PERF_EN
      chk($sformatf("d%0d_perf", d), (d == 0) ? perf0 : perf1, perf[d]);
`endif
    end
  endtask

  task automatic drive(input logic [N-1:0] r, input logic u);
    req = r;
    unl = u;
    #2;
    check_all();
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_clock();
    #1;
  endtask

  task automatic step(input logic [N-1:0] r, input logic u);
    drive(r, u);
    tick();
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    reset = 1'b1;
    req   = '0;
    unl   = 1'b0;
    #3;
    chk("rst_st0", st0, 4'b0000);
    chk("rst_gv0", gv0, 1'b0);
    req = 4'b0110;
    #1;
    chk("rst_plain_idx", gidx1, 2'd1);
    tick();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Two steady requesters, always accepted: 0,0,0,1 repeating.
    step(4'b0000, 1'b0);
    for (int c = 0; c < 12; c++) begin
      drive(4'b0011, 1'b1);
      chk("pat_idx", gidx0, (c % 4 == 3) ? 2'd1 : 2'd0);
      chk("pat_starved", st0, (c % 4 == 3) ? 4'b0010 : 4'b0000);
      tick();
    end

    // Nothing accepted: index 0 holds, ages saturate without wrapping.
    step(4'b0000, 1'b0);
    for (int c = 0; c < 20; c++) begin
      drive(4'b1111, 1'b0);
      chk("hold_idx", gidx0, 2'd0);
      if (c >= 3) chk("hold_starved", st0, 4'b1111);
      tick();
    end

    // Two starved requesters win in index order, then plain priority resumes.
    step(4'b0000, 1'b0);
    for (int c = 0; c < 3; c++) step(4'b1100, 1'b0);
    drive(4'b1101, 1'b1); chk("tie_k0", gidx0, 2'd2); tick();
    drive(4'b1101, 1'b1); chk("tie_k1", gidx0, 2'd3); tick();
    drive(4'b1101, 1'b1); chk("tie_k2", gidx0, 2'd0); tick();

    // Lock holds an unaccepted grant against a higher-priority newcomer.
    step(4'b0000, 1'b0);
    drive(4'b0110, 1'b0); chk("lock_c0", gidx1, 2'd1); tick();
    drive(4'b0111, 1'b1); chk("lock_c1", gidx1, 2'd1); chk("nolock_c1", gidx0, 2'd0); tick();
    drive(4'b0111, 1'b0); chk("lock_c2", gidx1, 2'd0); tick();

    // Withdrawal of the locked requester regrants immediately.
    step(4'b0000, 1'b0);
    drive(4'b0100, 1'b0); chk("wd_c0", gidx1, 2'd2); tick();
    drive(4'b1010, 1'b0); chk("wd_c1", gidx1, 2'd1); tick();
    step(4'b1000, 1'b1);

    // Asynchronous reset with a starved winner: falls back to lowest index at once.
    step(4'b0000, 1'b0);
    for (int c = 0; c < 4; c++) step(4'b0100, 1'b0);
    drive(4'b0101, 1'b0);
    chk("ar_pre_idx", gidx0, 2'd2);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("ar_starved0", st0, 4'b0000);
    chk("ar_starved1", st1, 4'b0000);
    chk("ar_idx0", gidx0, 2'd0);
    chk("ar_idx1", gidx1, 2'd0);
    check_all();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Random traffic, with occasional reset pulses.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        pulse_reset();
      end else begin
        step(N'($urandom), ($urandom_range(0, 3) != 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vx_aging_priority_arbiter.md
# vx_aging_priority_arbiter

Fixed-priority arbiter with per-requester aging, optional grant locking and an accept handshake. It is the successor to the plain priority arbiter used by the issue, memory and writeback crossbars. A requester left waiting for `MAX_AGE` cycles is promoted above all non-starved requesters, which bounds worst-case wait. Otherwise the lowest index wins.

## Interface
- `NUM_REQS`, 4, number of requesters (≥1)
- `LOCK_ENABLE`, 0, 1 = an unaccepted grant is held until accepted or withdrawn
- `AGE_WIDTH`, 4, width of each age counter
- `MAX_AGE`, 15, starvation threshold; legal range 1 ≤ MAX_AGE ≤ 2^AGE_WIDTH−1 (elaboration error otherwise)
- `LOG_NUM_REQS`, `LOG2UP(NUM_REQS)`, index width
- `clk` in 1 — single clock
- `reset` in 1 — asynchronous, active-high
- `requests` in NUM_REQS — request vector
- `unlock` in 1 — accept: current grant consumed this cycle
- `grant_index` out LOG_NUM_REQS — granted index
- `grant_onehot` out NUM_REQS — granted one-hot
- `grant_valid` out 1 — any grant
- `starved` out NUM_REQS — per-requester `age == MAX_AGE`
- `perf_promoted_grants` out 32 — present only with `VX_AGING_ARB_PERF_EN`

## Operation
- **Accept:** `accept = grant_valid && unlock`.
- **Selection (combinational):**
  - If `lock_valid`, and `requests[lock_idx]` is high, grant `lock_idx`.
  - Else, if any `starved & requests` bit is set, grant the lowest-index starved requester.
  - Else, grant the lowest-index requester.
  - No requests: `grant_valid=0`, `grant_onehot=0`, `grant_index=0`.
- **Age update (per i, posedge):**
  - Reset to 0 if `!requests[i]`, or if `accept` with grant to i.
  - Otherwise increment, saturating at `MAX_AGE` (never wraps).
- **Lock state** (only when `LOCK_ENABLE=1`; otherwise lock is tied off to 0):
  - States: `IDLE` (`lock_valid=0`) and `LOCKED` (`lock_valid=1`, `lock_idx`).
  - `IDLE`→`LOCKED` on `grant_valid && !unlock`; `lock_idx` ← `grant_index`.
  - `LOCKED`→`IDLE` on `accept`, or when `requests[lock_idx]` drops.
  - While `LOCKED`, no re-arbitration occurs, even if another requester is starved.
- **Degenerate case:** with `NUM_REQS==1`, grant mirrors `requests[0]`. Aging and lock logic are still present; `starved` is informational only.

## Timing
- Request→grant latency is 0 cycles (combinational). All state updates on posedge `clk`.
- **Reset values:**
  - All ages 0, lock `IDLE`, `perf_promoted_grants` 0, `starved` 0.
  - Grant outputs follow `requests` as plain priority during and immediately after reset.
- **Reset mid-operation:** ages and lock clear asynchronously. The grant in the same cycle reverts to lowest index.
- **Simultaneous events:**
  - Starvation and lock in the same cycle: lock wins.
  - Multiple starved requesters: lowest index wins; the others stay saturated and win on later accepts.
- **Lock timing:** the lock takes effect in cycle N+1 after an unaccepted grant in cycle N.

## Configuration
- `VX_AGING_ARB_PERF_EN` defined:
  - `perf_promoted_grants` port exists.
  - It increments by 1 on each `accept` whose grant came from the starvation path, excluding grants that came via lock.
  - It wraps at 2^32.
- Undefined: the port and counter are absent, and arbitration behaviour is identical.

## Structure
- Package `vx_arb_pkg`:
  - `arb_age_t` typedef, parametrised via localparam at use site or `logic [AGE_WIDTH-1:0]`.
  - Lock-state enum `arb_lock_state_e` {`ARB_IDLE`, `ARB_LOCKED`}.
- Sub-modules:
  - Two `VX_priority_encoder` instances: one over `starved & requests`, one over `requests`.
  - Per-requester counters built in a generate loop, no separate module.

## Test plan
- NUM_REQS=4, MAX_AGE=3, `requests=4'b0011` constant, `unlock=1` → grant_index pattern 0,0,0,1 repeating; `starved[1]` is high exactly in the cycle index 1 is granted.
- `unlock=0`, `requests=4'b1111` for 20 cycles, LOCK_ENABLE=0 → `grant_index=0` throughout; all ages saturate at 3 with no wrap; `starved=4'b1111` from cycle 3.
- Starvation tie: with 2 and 3 both starved and `unlock=1` → cycle k grants 2, cycle k+1 grants 3, then index 0 resumes.
- LOCK_ENABLE=1 sequence:
  - Cycle 0: `requests=4'b0110`, `unlock=0` → grant 1.
  - Cycle 1: `requests=4'b0111` → grant stays 1.
  - Cycle 1 `unlock=1` → cycle 2 grants 0.
- LOCK_ENABLE=1 withdrawal: locked on index 2, then `requests[2]` drops → same cycle grants lowest remaining requester; next cycle lock is `IDLE`.
- Async reset asserted mid-cycle with saturated ages → `starved` falls to 0 without a clock edge; the grant is the lowest-index request. With PERF_EN, the counter reads 0 and increments only on promoted accepts.
